// File: rtl/product_acc_pkg.sv
// Shared types and default widths for the product accumulator slice.
package product_acc_pkg;

    localparam int unsigned DEF_PROD_W    = 64;
    localparam int unsigned DEF_ACC_W     = 72;
    localparam int unsigned DEF_CNT_W     = 8;
    localparam int unsigned DEF_MAX_TERMS = 255;

    // All-ones value of the default-width accumulator (saturation ceiling).
    localparam logic [DEF_ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / sum-out handshake bundle between multiplier, accumulator and consumer.
interface product_accumulator_if
    import product_acc_pkg::*;
#(
    parameter int unsigned PROD_W = DEF_PROD_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
);

    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_overflow;

    // Accumulator side.
    modport slave (
        input  clear, in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow
    );

    // Producer/consumer side.
    modport master (
        output clear, in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow
    );

endinterface

// File: rtl/product_accumulator_acc_adder.sv
// Combinational accumulate step: acc + zero-extended product with carry-out.
// With PRODUCT_ACC_SAT_EN defined the sum clamps to all-ones on carry-out;
// an already saturated accumulator then stays saturated on later adds.
module acc_adder
    import product_acc_pkg::*;
#(
    parameter int unsigned PROD_W = DEF_PROD_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum_c,
    output logic              carry_c
);

    logic [ACC_W:0] full_c;

    // Wide add, carry extraction and optional saturation.
    always_comb begin
        full_c  = {1'b0, acc} + {1'b0, ACC_W'(product)};
        carry_c = full_c[ACC_W];
`ifdef PRODUCT_ACC_SAT_EN
        sum_c   = carry_c ? '1 : full_c[ACC_W-1:0];
`else
        sum_c   = full_c[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a stream of multiplier products and emits the running sum on a
// valid/ready port when the last term arrives or MAX_TERMS terms are taken.
// Build option: PRODUCT_ACC_SAT_EN selects saturating instead of wrapping sums.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int unsigned PROD_W    = DEF_PROD_W,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned MAX_TERMS = DEF_MAX_TERMS
) (
    input  logic                  clk,
    input  logic                  rst,
    product_accumulator_if.slave  bus
);

    acc_state_e       state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf, ovf_nxt;

    logic             in_ready_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q, out_sum_nxt;
    logic [CNT_W-1:0] out_count_q, out_count_nxt;
    logic             out_ovf_q, out_ovf_nxt;

    logic [ACC_W-1:0] add_sum_c;
    logic             add_carry_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             flush_c;

    acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .acc     (acc),
        .product (bus.in_product),
        .sum_c   (add_sum_c),
        .carry_c (add_carry_c)
    );

    // Term count after this accept and whether it closes the sequence.
    always_comb begin
        cnt_inc_c = cnt + CNT_W'(1);
        flush_c   = bus.in_last || (cnt_inc_c == CNT_W'(MAX_TERMS));
    end

    // Next state: clear aborts everything, otherwise accept in ACCUM or drain in HOLD.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        ovf_nxt       = ovf;
        out_sum_nxt   = out_sum_q;
        out_count_nxt = out_count_q;
        out_ovf_nxt   = out_ovf_q;

        if (bus.clear) begin
            state_nxt     = ACCUM;
            acc_nxt       = '0;
            cnt_nxt       = '0;
            ovf_nxt       = 1'b0;
            out_sum_nxt   = '0;
            out_count_nxt = '0;
            out_ovf_nxt   = 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_nxt = add_sum_c;
                        cnt_nxt = cnt_inc_c;
                        ovf_nxt = ovf | add_carry_c;
                        if (flush_c) begin
                            state_nxt     = HOLD;
                            out_sum_nxt   = add_sum_c;
                            out_count_nxt = cnt_inc_c;
                            out_ovf_nxt   = ovf | add_carry_c;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_nxt = ACCUM;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        ovf_nxt   = 1'b0;
                    end
                end
            endcase
        end
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            cnt         <= cnt_nxt;
            ovf         <= ovf_nxt;
            in_ready_q  <= (state_nxt == ACCUM);
            out_valid_q <= (state_nxt == HOLD);
            out_sum_q   <= out_sum_nxt;
            out_count_q <= out_count_nxt;
            out_ovf_q   <= out_ovf_nxt;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sum      = out_sum_q;
    assign bus.out_count    = out_count_q;
    assign bus.out_overflow = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed scenarios plus randomized traffic
// against a transaction-level model, on a 72-bit/255-term instance (A) and a
// 64-bit/4-term instance (B).
module tb_product_accumulator;
    import product_acc_pkg::*;

    localparam int unsigned A_ACC_W = 72;
    localparam int unsigned B_ACC_W = 64;
    localparam int unsigned A_MAX   = 255;
    localparam int unsigned B_MAX   = 4;

    logic clk;
    logic rst;

    product_accumulator_if #(.PROD_W(64), .ACC_W(A_ACC_W), .CNT_W(8)) bus_a ();
    product_accumulator_if #(.PROD_W(64), .ACC_W(B_ACC_W), .CNT_W(8)) bus_b ();

    product_accumulator #(
        .PROD_W(64), .ACC_W(A_ACC_W), .CNT_W(8), .MAX_TERMS(A_MAX)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    product_accumulator #(
        .PROD_W(64), .ACC_W(B_ACC_W), .CNT_W(8), .MAX_TERMS(B_MAX)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Bench-driven inputs per instance.
    logic        v    [2];
    logic        l    [2];
    logic        ordy [2];
    logic        clr  [2];
    logic [63:0] p    [2];

    // Observed outputs per instance (sums widened to 72 bits).
    logic        o_rdy [2];
    logic        o_vld [2];
    logic        o_ovf [2];
    logic [71:0] o_sum [2];
    logic [7:0]  o_cnt [2];

    assign bus_a.in_valid   = v[0];
    assign bus_a.in_last    = l[0];
    assign bus_a.in_product = p[0];
    assign bus_a.out_ready  = ordy[0];
    assign bus_a.clear      = clr[0];
    assign bus_b.in_valid   = v[1];
    assign bus_b.in_last    = l[1];
    assign bus_b.in_product = p[1];
    assign bus_b.out_ready  = ordy[1];
    assign bus_b.clear      = clr[1];

    assign o_rdy[0] = bus_a.in_ready;
    assign o_vld[0] = bus_a.out_valid;
    assign o_ovf[0] = bus_a.out_overflow;
    assign o_sum[0] = bus_a.out_sum;
    assign o_cnt[0] = bus_a.out_count;
    assign o_rdy[1] = bus_b.in_ready;
    assign o_vld[1] = bus_b.out_valid;
    assign o_ovf[1] = bus_b.out_overflow;
    assign o_sum[1] = {8'h00, bus_b.out_sum};
    assign o_cnt[1] = bus_b.out_count;

    // Reference model: exact (unbounded) total of accepted terms, term count,
    // whether a finished sum is pending, and whether outputs are known zero.
    logic [127:0] m_tot  [2];
    int unsigned  m_cnt  [2];
    bit           m_hold [2];
    bit           m_zero [2];

    int n_cmp;
    int n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_step(input int k);
        int unsigned mx;
        mx = (k == 0) ? A_MAX : B_MAX;
        if (rst || clr[k]) begin
            m_tot[k]  = '0;
            m_cnt[k]  = 0;
            m_hold[k] = 1'b0;
            m_zero[k] = 1'b1;
        end else if (m_hold[k]) begin
            if (ordy[k]) begin
                m_hold[k] = 1'b0;
                m_tot[k]  = '0;
                m_cnt[k]  = 0;
            end
        end else if (v[k]) begin
            m_tot[k] = m_tot[k] + 128'(p[k]);
            m_cnt[k] = m_cnt[k] + 1;
            if (l[k] || m_cnt[k] == mx) begin
                m_hold[k] = 1'b1;
                m_zero[k] = 1'b0;
            end
        end
    endfunction

    // The sequence overflowed iff its exact total does not fit in ACC_W bits.
    function automatic bit exp_ovf(input int k);
        int unsigned w;
        w = (k == 0) ? A_ACC_W : B_ACC_W;
        return (m_tot[k] >> w) != 128'd0;
    endfunction

    function automatic logic [71:0] exp_sum(input int k);
        int unsigned  w;
        logic [127:0] mask;
        w    = (k == 0) ? A_ACC_W : B_ACC_W;
        mask = (128'd1 << w) - 128'd1;
`ifdef PRODUCT_ACC_SAT_EN
        if (exp_ovf(k)) return 72'(mask);
`endif
        return 72'(m_tot[k] & mask);
    endfunction

    // Drive one cycle on instance s (other instance idle), advance the model.
    task automatic tick(input int s, input bit iv, input logic [63:0] ip, input bit il,
                        input bit ior, input bit icl, input bit ir);
        for (int k = 0; k < 2; k++) begin
            v[k] = 1'b0; l[k] = 1'b0; ordy[k] = 1'b0; clr[k] = 1'b0; p[k] = '0;
        end
        v[s] = iv; p[s] = ip; l[s] = il; ordy[s] = ior; clr[s] = icl;
        rst = ir;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 64'd0, 0, 0, 0, 1);
        tick(0, 0, 64'd0, 0, 0, 0, 1);
        tick(0, 0, 64'd0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (o_rdy[k] !== 1'b1 || o_vld[k] !== 1'b0 || o_sum[k] !== 72'd0 ||
                o_cnt[k] !== 8'd0 || o_ovf[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset[%0d]: rdy=%b vld=%b sum=%h cnt=%0d ovf=%b, want 1 0 0 0 0",
                         k, o_rdy[k], o_vld[k], o_sum[k], o_cnt[k], o_ovf[k]);
            end
        end
    endtask

    task automatic test_basic();
        tick(0, 1, 64'd3, 0, 1, 0, 0);
        tick(0, 1, 64'd5, 0, 1, 0, 0);
        n_cmp++;
        if (o_rdy[0] !== 1'b1 || o_vld[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_mid: rdy=%b vld=%b, want 1 0", o_rdy[0], o_vld[0]);
        end
        tick(0, 1, 64'd7, 1, 1, 0, 0);
        n_cmp++;
        if (o_vld[0] !== 1'b1 || o_rdy[0] !== 1'b0 || o_sum[0] !== 72'd15 ||
            o_cnt[0] !== 8'd3 || o_ovf[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_out: vld=%b rdy=%b sum=%0d cnt=%0d ovf=%b, want 1 0 15 3 0",
                     o_vld[0], o_rdy[0], o_sum[0], o_cnt[0], o_ovf[0]);
        end
        tick(0, 0, 64'd0, 0, 1, 0, 0);
        n_cmp++;
        if (o_rdy[0] !== 1'b1 || o_vld[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_release: rdy=%b vld=%b, want 1 0", o_rdy[0], o_vld[0]);
        end
    endtask

    task automatic test_hold_stall();
        tick(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (o_rdy[0] !== 1'b0 || o_vld[0] !== 1'b1 ||
                o_sum[0] !== 72'h00_FFFF_FFFF_FFFF_FFFF || o_cnt[0] !== 8'd1 || o_ovf[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL stall[%0d]: rdy=%b vld=%b sum=%h cnt=%0d ovf=%b, want 0 1 ffffffffffffffff 1 0",
                         i, o_rdy[0], o_vld[0], o_sum[0], o_cnt[0], o_ovf[0]);
            end
            if (i < 4) tick(0, 1, 64'h1234, 0, 0, 0, 0);
        end
        tick(0, 0, 64'd0, 0, 1, 0, 0);
        n_cmp++;
        if (o_rdy[0] !== 1'b1 || o_vld[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_release: rdy=%b vld=%b, want 1 0", o_rdy[0], o_vld[0]);
        end
        tick(0, 1, 64'd5, 1, 0, 0, 0);
        n_cmp++;
        if (o_vld[0] !== 1'b1 || o_sum[0] !== 72'd5 || o_cnt[0] !== 8'd1) begin
            n_bad++;
            $display("FAIL stall_next: vld=%b sum=%0d cnt=%0d, want 1 5 1", o_vld[0], o_sum[0], o_cnt[0]);
        end
        tick(0, 0, 64'd0, 0, 1, 0, 0);
    endtask

    task automatic test_wrap();
        logic [71:0] want;
`ifdef PRODUCT_ACC_SAT_EN
        want = 72'h00_FFFF_FFFF_FFFF_FFFF;
`else
        want = 72'd1;
`endif
        tick(1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
        tick(1, 1, 64'd2, 1, 0, 0, 0);
        n_cmp++;
        if (o_vld[1] !== 1'b1 || o_sum[1] !== want || o_cnt[1] !== 8'd2 || o_ovf[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap: vld=%b sum=%h cnt=%0d ovf=%b, want 1 %h 2 1",
                     o_vld[1], o_sum[1], o_cnt[1], o_ovf[1], want);
        end
        tick(1, 0, 64'd0, 0, 1, 0, 0);
        n_cmp++;
        if (o_rdy[1] !== 1'b1 || o_vld[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_release: rdy=%b vld=%b, want 1 0", o_rdy[1], o_vld[1]);
        end
    endtask

    task automatic test_max_terms();
        for (int blk = 0; blk < 2; blk++) begin
            for (int i = 0; i < 4; i++) begin
                tick(1, 1, 64'd1, 0, 1, 0, 0);
                if (i == 2) begin
                    n_cmp++;
                    if (o_vld[1] !== 1'b0 || o_rdy[1] !== 1'b1) begin
                        n_bad++;
                        $display("FAIL max_mid[%0d]: vld=%b rdy=%b, want 0 1", blk, o_vld[1], o_rdy[1]);
                    end
                end
            end
            n_cmp++;
            if (o_vld[1] !== 1'b1 || o_rdy[1] !== 1'b0 || o_sum[1] !== 72'd4 ||
                o_cnt[1] !== 8'd4 || o_ovf[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL max_out[%0d]: vld=%b rdy=%b sum=%0d cnt=%0d ovf=%b, want 1 0 4 4 0",
                         blk, o_vld[1], o_rdy[1], o_sum[1], o_cnt[1], o_ovf[1]);
            end
            tick(1, 1, 64'd1, 0, 1, 0, 0);
            n_cmp++;
            if (o_rdy[1] !== 1'b1 || o_vld[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL max_gap[%0d]: rdy=%b vld=%b, want 1 0", blk, o_rdy[1], o_vld[1]);
            end
        end
    endtask

    task automatic test_clear();
        tick(0, 1, 64'd10, 0, 0, 0, 0);
        tick(0, 1, 64'd20, 0, 0, 0, 0);
        tick(0, 1, 64'd30, 0, 0, 1, 0);
        n_cmp++;
        if (o_vld[0] !== 1'b0 || o_rdy[0] !== 1'b1 || o_sum[0] !== 72'd0 ||
            o_cnt[0] !== 8'd0 || o_ovf[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_accum: vld=%b rdy=%b sum=%0d cnt=%0d ovf=%b, want 0 1 0 0 0",
                     o_vld[0], o_rdy[0], o_sum[0], o_cnt[0], o_ovf[0]);
        end
        tick(0, 1, 64'd9, 1, 0, 0, 0);
        n_cmp++;
        if (o_vld[0] !== 1'b1 || o_sum[0] !== 72'd9 || o_cnt[0] !== 8'd1) begin
            n_bad++;
            $display("FAIL clear_next: vld=%b sum=%0d cnt=%0d, want 1 9 1", o_vld[0], o_sum[0], o_cnt[0]);
        end
        tick(0, 0, 64'd0, 0, 0, 1, 0);
        n_cmp++;
        if (o_vld[0] !== 1'b0 || o_rdy[0] !== 1'b1 || o_sum[0] !== 72'd0 || o_cnt[0] !== 8'd0) begin
            n_bad++;
            $display("FAIL clear_hold: vld=%b rdy=%b sum=%0d cnt=%0d, want 0 1 0 0",
                     o_vld[0], o_rdy[0], o_sum[0], o_cnt[0]);
        end
    endtask

    task automatic test_reset_in_hold();
        tick(0, 1, 64'd42, 1, 0, 0, 0);
        tick(0, 0, 64'd0, 0, 1, 0, 1);
        n_cmp++;
        if (o_rdy[0] !== 1'b1 || o_vld[0] !== 1'b0 || o_sum[0] !== 72'd0 ||
            o_cnt[0] !== 8'd0 || o_ovf[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b, want 1 0 0 0 0",
                     o_rdy[0], o_vld[0], o_sum[0], o_cnt[0], o_ovf[0]);
        end
        tick(0, 0, 64'd0, 0, 0, 0, 0);
    endtask

    task automatic test_random(input int s, input int n);
        logic [63:0] rp;
        bit          rv, rl, ro, rc;
        logic [71:0] es;
        logic [7:0]  ec;
        bit          eo;
        for (int i = 0; i < n; i++) begin
            rp = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) rp = 64'd0 + 64'($urandom_range(0, 3));
            rv = ($urandom_range(0, 3) != 0);
            rl = ($urandom_range(0, 5) == 0);
            ro = ($urandom_range(0, 2) != 0);
            rc = ($urandom_range(0, 40) == 0);
            tick(s, rv, rp, rl, ro, rc, 1'b0);
            n_cmp++;
            if (o_rdy[s] !== !m_hold[s] || o_vld[s] !== m_hold[s]) begin
                n_bad++;
                $display("FAIL rand_hs[%0d/%0d]: rdy=%b vld=%b, want %b %b",
                         s, i, o_rdy[s], o_vld[s], !m_hold[s], m_hold[s]);
            end
            if (m_hold[s] || m_zero[s]) begin
                es = m_hold[s] ? exp_sum(s) : 72'd0;
                ec = m_hold[s] ? 8'(m_cnt[s]) : 8'd0;
                eo = m_hold[s] ? exp_ovf(s) : 1'b0;
                n_cmp++;
                if (o_sum[s] !== es || o_cnt[s] !== ec || o_ovf[s] !== eo) begin
                    n_bad++;
                    $display("FAIL rand_out[%0d/%0d]: sum=%h cnt=%0d ovf=%b, want %h %0d %b",
                             s, i, o_sum[s], o_cnt[s], o_ovf[s], es, ec, eo);
                end
            end
        end
        tick(s, 0, 64'd0, 0, 1, 0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            v[k] = 1'b0; l[k] = 1'b0; ordy[k] = 1'b0; clr[k] = 1'b0; p[k] = '0;
            m_tot[k] = '0; m_cnt[k] = 0; m_hold[k] = 1'b0; m_zero[k] = 1'b1;
        end
        test_reset();
        test_basic();
        test_hold_stall();
        test_wrap();
        test_max_terms();
        test_clear();
        test_reset_in_hold();
        test_random(0, 400);
        test_random(1, 400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
